lowspeed_initiator: RTL and testbench

//  Host-side initiator for the lowspeed byte protocol: sends opcode + argument bytes out a byte

---
 rtl/lowspeed_pkg.sv | 30 +++
 rtl/lowspeed_timeout.sv | 31 +++
 rtl/lowspeed_initiator.sv | 204 ++++++++++++++++++++
 tb/tb_lowspeed_initiator.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lowspeed_pkg.sv
// rtl/lowspeed_pkg.sv - shared states, opcodes and limits for the lowspeed byte protocol
package lowspeed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_SEND_ARG,
        ST_SEND_CSUM,
        ST_WAIT_RESP,
        ST_DONE
    } ls_state_t;

    // Opcodes understood by lowspeed_core on the far side of the link.
    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_ECHO      = 8'h01;
    localparam logic [7:0] OP_READ_REG  = 8'h02;
    localparam logic [7:0] OP_WRITE_REG = 8'h03;
    localparam logic [7:0] OP_STATUS    = 8'h04;
    localparam logic [7:0] OP_SELFTEST  = 8'h05;

    localparam int LS_MAX_ARGS_LIMIT = 7;
    localparam int LS_MAX_RESP_LIMIT = 7;

    localparam logic [7:0] CSUM_INIT = 8'h00;

    function automatic logic [2:0] clamp_count(input logic [2:0] n, input logic [2:0] limit);
        return (n > limit) ? limit : n;
    endfunction

endpackage

// File: rtl/lowspeed_timeout.sv
// rtl/lowspeed_timeout.sv - clear/enable saturating idle counter with expired flag
module lowspeed_timeout #(
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT    = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LIMIT_M1 = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + W'(1);
        end
    end

    // Flags the clock on which the count reaches the limit so the consumer can act on that same edge.
    assign expired = (count == LIMIT) || (enable && !clear && count == LIMIT_M1);

endmodule

// File: rtl/lowspeed_initiator.sv
// rtl/lowspeed_initiator.sv - lowspeed command initiator; optional LOWSPEED_INITIATOR_CHECKSUM_EN
module lowspeed_initiator
    import lowspeed_pkg::*;
#(
    parameter int MAX_ARGS       = 4,
    parameter int MAX_RESP       = 4,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [7:0]            cmd_opcode_i,
    input  logic [8*MAX_ARGS-1:0] cmd_args_i,
    input  logic [2:0]            cmd_nargs_i,
    input  logic [2:0]            cmd_nresp_i,
    output logic [7:0]            write_data_o,
    output logic                  write_valid_o,
    input  logic                  write_ready_i,
    input  logic [7:0]            read_data_i,
    input  logic                  read_valid_i,
    output logic                  resp_valid_o,
    output logic [8*MAX_RESP-1:0] resp_data_o,
    output logic [2:0]            resp_count_o,
    output logic                  resp_timeout_o,
    output logic                  resp_bad_csum_o,
    output logic                  error_unexpected_o
);

`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
    localparam ls_state_t ST_AFTER_ARGS = ST_SEND_CSUM;
`else
    localparam ls_state_t ST_AFTER_ARGS = ST_WAIT_RESP;
`endif

    ls_state_t             state;
    logic [7:0]            opcode_q;
    logic [8*MAX_ARGS-1:0] args_q;
    logic [2:0]            nargs_q;
    logic [2:0]            nresp_q;
    logic [2:0]            arg_idx;
    logic                  guard_q;
    logic [7:0]            tx_byte;
    logic                  sending;
    logic                  strobe;
    logic                  last_arg;
    logic                  tmo_clear;
    logic                  tmo_enable;
    logic                  tmo_expired;
`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
    logic [7:0]            tx_csum;
    logic [7:0]            rx_csum;
`endif

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            ST_SEND_OP:   tx_byte = opcode_q;
            ST_SEND_ARG:  tx_byte = args_q[8*int'(arg_idx) +: 8];
`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
            ST_SEND_CSUM: tx_byte = tx_csum;
`endif
            default:      tx_byte = 8'h00;
        endcase
    end

    // The transmitter's busy flag lags a write by one clock, so a strobe is never issued
    // in the cycle right after another one.
    assign sending       = (state == ST_SEND_OP) || (state == ST_SEND_ARG) || (state == ST_SEND_CSUM);
    assign strobe        = sending && !guard_q && write_ready_i;
    assign write_valid_o = strobe;
    assign write_data_o  = strobe ? tx_byte : 8'h00;
    assign last_arg      = (arg_idx == nargs_q - 3'd1);
    assign cmd_ready_o   = (state == ST_IDLE);

    assign tmo_enable = (state == ST_WAIT_RESP);
    assign tmo_clear  = (state != ST_WAIT_RESP) || read_valid_i;

    lowspeed_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

`ifndef LOWSPEED_INITIATOR_CHECKSUM_EN
    assign resp_bad_csum_o = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            opcode_q           <= '0;
            args_q             <= '0;
            nargs_q            <= '0;
            nresp_q            <= '0;
            arg_idx            <= '0;
            guard_q            <= 1'b0;
            resp_valid_o       <= 1'b0;
            resp_data_o        <= '0;
            resp_count_o       <= '0;
            resp_timeout_o     <= 1'b0;
            error_unexpected_o <= 1'b0;
`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
            tx_csum            <= CSUM_INIT;
            rx_csum            <= CSUM_INIT;
            resp_bad_csum_o    <= 1'b0;
`endif
        end else begin
            resp_valid_o       <= 1'b0;
            guard_q            <= strobe;
            error_unexpected_o <= read_valid_i && (state != ST_WAIT_RESP);
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        opcode_q       <= cmd_opcode_i;
                        args_q         <= cmd_args_i;
                        nargs_q        <= clamp_count(cmd_nargs_i, 3'(MAX_ARGS));
                        nresp_q        <= clamp_count(cmd_nresp_i, 3'(MAX_RESP));
                        resp_data_o    <= '0;
                        resp_count_o   <= '0;
                        resp_timeout_o <= 1'b0;
`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
                        tx_csum         <= CSUM_INIT ^ cmd_opcode_i;
                        rx_csum         <= CSUM_INIT;
                        resp_bad_csum_o <= 1'b0;
`endif
                        state          <= ST_SEND_OP;
                    end
                end
                ST_SEND_OP: begin
                    if (strobe) begin
                        arg_idx <= '0;
                        state   <= (nargs_q == 3'd0) ? ST_AFTER_ARGS : ST_SEND_ARG;
                    end
                end
                ST_SEND_ARG: begin
                    if (strobe) begin
`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
                        tx_csum <= tx_csum ^ tx_byte;
`endif
                        arg_idx <= arg_idx + 3'd1;
                        if (last_arg) begin
                            state <= ST_AFTER_ARGS;
                        end
                    end
                end
`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
                ST_SEND_CSUM: begin
                    if (strobe) begin
                        state <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    // The byte after the last data byte is the sender's checksum and is not stored.
                    if (read_valid_i) begin
                        if (resp_count_o == nresp_q) begin
                            resp_bad_csum_o <= (read_data_i != rx_csum);
                            resp_valid_o    <= 1'b1;
                            state           <= ST_DONE;
                        end else begin
                            resp_data_o[8*int'(resp_count_o) +: 8] <= read_data_i;
                            resp_count_o <= resp_count_o + 3'd1;
                            rx_csum      <= rx_csum ^ read_data_i;
                        end
                    end else if (tmo_expired) begin
                        resp_timeout_o <= 1'b1;
                        resp_valid_o   <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
`else
                ST_WAIT_RESP: begin
                    if (nresp_q == 3'd0) begin
                        resp_valid_o <= 1'b1;
                        state        <= ST_DONE;
                    end else if (read_valid_i) begin
                        resp_data_o[8*int'(resp_count_o) +: 8] <= read_data_i;
                        resp_count_o <= resp_count_o + 3'd1;
                        if (resp_count_o + 3'd1 == nresp_q) begin
                            resp_valid_o <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end else if (tmo_expired) begin
                        resp_timeout_o <= 1'b1;
                        resp_valid_o   <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lowspeed_initiator.sv
// tb/tb_lowspeed_initiator.sv - randomized self-checking bench for lowspeed_initiator
module tb_lowspeed_initiator;

    localparam int MAX_ARGS = 4;
    localparam int MAX_RESP = 4;
    localparam int TMO      = 64;
`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  cmd_valid_i = 1'b0;
    logic                  cmd_ready_o;
    logic [7:0]            cmd_opcode_i = '0;
    logic [8*MAX_ARGS-1:0] cmd_args_i = '0;
    logic [2:0]            cmd_nargs_i = '0;
    logic [2:0]            cmd_nresp_i = '0;
    logic [7:0]            write_data_o;
    logic                  write_valid_o;
    logic                  write_ready_i;
    logic [7:0]            read_data_i = '0;
    logic                  read_valid_i = 1'b0;
    logic                  resp_valid_o;
    logic [8*MAX_RESP-1:0] resp_data_o;
    logic [2:0]            resp_count_o;
    logic                  resp_timeout_o;
    logic                  resp_bad_csum_o;
    logic                  error_unexpected_o;

    lowspeed_initiator #(
        .MAX_ARGS(MAX_ARGS),
        .MAX_RESP(MAX_RESP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_opcode_i(cmd_opcode_i), .cmd_args_i(cmd_args_i),
        .cmd_nargs_i(cmd_nargs_i), .cmd_nresp_i(cmd_nresp_i),
        .write_data_o(write_data_o), .write_valid_o(write_valid_o), .write_ready_i(write_ready_i),
        .read_data_i(read_data_i), .read_valid_i(read_valid_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_count_o(resp_count_o),
        .resp_timeout_o(resp_timeout_o), .resp_bad_csum_o(resp_bad_csum_o),
        .error_unexpected_o(error_unexpected_o)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0]  tx_q[$];
    int          err_cnt = 0;
    int          resp_cnt = 0;
    int          viol = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] got_data;
    logic [2:0]  got_count;
    logic        got_tmo, got_bad;
    int          resp_cyc = 0;
    int          ready_mode = 0;
    int          resp_base = 0;
    int          last_cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter model: 0 = always idle, 1 = random busy, 2 = held busy.
    initial begin
        write_ready_i = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                0:       write_ready_i = 1'b1;
                1:       write_ready_i = ($urandom_range(0, 2) != 0);
                default: write_ready_i = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (write_valid_o) begin
                    if (!write_ready_i || prev_valid) viol++;
                    tx_q.push_back(write_data_o);
                end
                if (error_unexpected_o) err_cnt++;
                if (resp_valid_o) begin
                    resp_cnt++;
                    got_data  = resp_data_o;
                    got_count = resp_count_o;
                    got_tmo   = resp_timeout_o;
                    got_bad   = resp_bad_csum_o;
                    resp_cyc  = cyc;
                end
                prev_valid = write_valid_o;
            end
        end
    end

    task automatic pulse_read(input logic [7:0] b);
        read_data_i  = b;
        read_valid_i = 1'b1;
        last_cyc     = cyc;
        @(posedge clock); #1;
        read_valid_i = 1'b0;
        read_data_i  = 8'h00;
    endtask

    task automatic issue_cmd(input string tag, input logic [7:0] op, input logic [31:0] args,
                             input int nargs, input int nresp);
        int k = 0;
        while (!cmd_ready_o && k < 50) begin
            @(posedge clock); #1;
            k++;
        end
        check_eq({tag, " cmd_ready"}, cmd_ready_o, 1);
        tx_q.delete();
        resp_base    = resp_cnt;
        cmd_opcode_i = op;
        cmd_args_i   = args;
        cmd_nargs_i  = 3'(nargs);
        cmd_nresp_i  = 3'(nresp);
        cmd_valid_i  = 1'b1;
        @(posedge clock); #1;
        cmd_valid_i  = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input logic [7:0] op, input logic [31:0] args,
                              input int nargs, input int nresp, input logic [7:0] reply[$]);
        logic [7:0]  exp_tx[$];
        logic [7:0]  x;
        logic [63:0] exp_pack, got_pack;
        logic [31:0] exp_data;
        int na, nr, need, ndata, k;
        logic exp_tmo, exp_bad;
        na = (nargs > MAX_ARGS) ? MAX_ARGS : nargs;
        nr = (nresp > MAX_RESP) ? MAX_RESP : nresp;
        exp_tx.push_back(op);
        x = op;
        for (int i = 0; i < na; i++) begin
            exp_tx.push_back(args[8*i +: 8]);
            x = x ^ args[8*i +: 8];
        end
        if (CSUM != 0) exp_tx.push_back(x);

        k = 0;
        while (tx_q.size() < exp_tx.size() && k < 400) begin
            @(posedge clock); #1;
            k++;
        end
        foreach (reply[i]) begin
            pulse_read(reply[i]);
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end
        k = 0;
        while (resp_cnt == resp_base && k < TMO + 100) begin
            @(posedge clock); #1;
            k++;
        end
        check_eq({tag, " resp_valid_pulses"}, resp_cnt - resp_base, 1);

        exp_pack = '0;
        got_pack = '0;
        foreach (exp_tx[i]) exp_pack[8*i +: 8] = exp_tx[i];
        foreach (tx_q[i]) if (i < 8) got_pack[8*i +: 8] = tx_q[i];
        check_eq({tag, " tx_count"}, tx_q.size(), exp_tx.size());
        check_eq({tag, " tx_bytes"}, got_pack, exp_pack);

        need     = nr + CSUM;
        ndata    = (reply.size() < nr) ? reply.size() : nr;
        exp_data = '0;
        x        = 8'h00;
        for (int i = 0; i < ndata; i++) begin
            exp_data[8*i +: 8] = reply[i];
            x = x ^ reply[i];
        end
        exp_tmo = (reply.size() < need);
        exp_bad = (CSUM != 0) && !exp_tmo && (reply[nr] != x);
        check_eq({tag, " resp_data"}, got_data, exp_data);
        check_eq({tag, " resp_count"}, got_count, ndata);
        check_eq({tag, " resp_timeout"}, got_tmo, exp_tmo);
        check_eq({tag, " resp_bad_csum"}, got_bad, exp_bad);
        // The last byte is latched at the end of its strobe cycle; the timeout spans TMO clocks from there.
        if (exp_tmo && reply.size() > 0)
            check_eq({tag, " timeout_latency"}, resp_cyc - last_cyc, TMO + 1);
    endtask

    initial begin
        logic [7:0]  rep[$];
        logic [7:0]  op, x;
        logic [31:0] args;
        int nargs, nresp, nr, need, e0, base, txs, k;

        #900_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rep[$];
        logic [7:0]  op, x;
        logic [31:0] args;
        int nargs, nresp, nr, need, e0, base, txs, k;

        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset cmd_ready", cmd_ready_o, 1);
        check_eq("reset write_valid", write_valid_o, 0);
        check_eq("reset write_data", write_data_o, 0);
        check_eq("reset resp_valid", resp_valid_o, 0);
        check_eq("reset resp_data", resp_data_o, 0);
        check_eq("reset resp_count", resp_count_o, 0);
        check_eq("reset resp_timeout", resp_timeout_o, 0);
        check_eq("reset bad_csum", resp_bad_csum_o, 0);
        check_eq("reset unexpected", error_unexpected_o, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Loopback: responder echoes the two argument bytes.
        rep = '{8'h12, 8'h34};
        if (CSUM != 0) rep.push_back(8'h12 ^ 8'h34);
        issue_cmd("loopback", 8'h01, 32'h0000_3412, 2, 2);
        finish_cmd("loopback", 8'h01, 32'h0000_3412, 2, 2, rep);

        // Stray byte while idle, then another during a stalled argument phase.
        e0 = err_cnt;
        pulse_read(8'h99);
        repeat (2) begin @(posedge clock); #1; end
        check_eq("idle unexpected", err_cnt - e0, 1);
        check_eq("idle still ready", cmd_ready_o, 1);
        issue_cmd("stall", 8'h02, 32'hA1B2_C3D4, 4, 1);
        k = 0;
        while (tx_q.size() < 2 && k < 50) begin @(posedge clock); #1; k++; end
        ready_mode = 2;
        @(posedge clock); #1;
        pulse_read(8'h77);
        repeat (50) @(posedge clock);
        #1;
        check_eq("stall tx_held", tx_q.size(), 2);
        ready_mode = 0;
        rep = '{8'h5A};
        if (CSUM != 0) rep.push_back(8'h5A);
        finish_cmd("stall", 8'h02, 32'hA1B2_C3D4, 4, 1, rep);
        check_eq("unexpected total", err_cnt - e0, 2);

        // Timeout: three bytes expected, one delivered.
        rep = '{8'hC3};
        issue_cmd("timeout", 8'h03, 32'h0000_0077, 1, 3);
        finish_cmd("timeout", 8'h03, 32'h0000_0077, 1, 3, rep);

        // Reset while arguments are being sent.
        issue_cmd("rst", 8'h04, 32'h0011_2233, 3, 2);
        k = 0;
        while (tx_q.size() < 1 && k < 50) begin @(posedge clock); #1; k++; end
        ready_mode = 2;
        repeat (3) begin @(posedge clock); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst write_valid", write_valid_o, 0);
        check_eq("rst cmd_ready", cmd_ready_o, 1);
        check_eq("rst resp_count", resp_count_o, 0);
        repeat (2) begin @(posedge clock); #1; end
        ready_mode = 0;
        base = resp_cnt;
        txs  = tx_q.size();
        reset_n = 1'b1;
        repeat (30) begin @(posedge clock); #1; end
        check_eq("rst no_resp", resp_cnt - base, 0);
        check_eq("rst no_tx", tx_q.size(), txs);
        check_eq("rst ready_after", cmd_ready_o, 1);

`ifdef LOWSPEED_INITIATOR_CHECKSUM_EN
        rep = '{8'hAA, 8'hBB, 8'h11};
        issue_cmd("csum_ok", 8'h05, 32'h0000_000F, 1, 2);
        finish_cmd("csum_ok", 8'h05, 32'h0000_000F, 1, 2, rep);
        check_eq("csum_ok tx_csum", (tx_q.size() > 2) ? tx_q[2] : 8'h00, 8'h0A);
        check_eq("csum_ok flag", got_bad, 0);
        rep = '{8'hAA, 8'hBB, 8'h12};
        issue_cmd("csum_bad", 8'h05, 32'h0000_000F, 1, 2);
        finish_cmd("csum_bad", 8'h05, 32'h0000_000F, 1, 2, rep);
        check_eq("csum_bad flag", got_bad, 1);
`endif

        // Randomized commands with a jittery transmitter, clamped counts and short replies.
        ready_mode = 1;
        e0 = err_cnt;
        for (int it = 0; it < 25; it++) begin
            op    = 8'($urandom);
            args  = $urandom;
            nargs = $urandom_range(0, 7);
            nresp = $urandom_range(0, 7);
            nr    = (nresp > MAX_RESP) ? MAX_RESP : nresp;
            need  = nr + CSUM;
            rep.delete();
            x = 8'h00;
            for (int i = 0; i < nr; i++) begin
                rep.push_back(8'($urandom));
                x = x ^ rep[i];
            end
            if (CSUM != 0)
                rep.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
            if (need > 0 && $urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, need - 1);
                while (rep.size() > k) void'(rep.pop_back());
            end
            issue_cmd($sformatf("rand%0d", it), op, args, nargs, nresp);
            finish_cmd($sformatf("rand%0d", it), op, args, nargs, nresp, rep);
        end
        ready_mode = 0;
        check_eq("rand unexpected", err_cnt - e0, 0);
        check_eq("strobe protocol violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
